iterative_divider_responder: RTL and testbench
==============================================

// Module: iterative_divider_responder
// PURPOSE
//   Responder side of the lhs/rhs/result valid-ready division channels used by the
//   top-level division harnesses.
//   Accepts an unsigned dividend (lhs) and divisor (rhs) on two independent input
//   channels, and computes the quotient by restoring division at one bit per cycle.
//   Presents the quotient on a result channel and holds it until consumed.
//   Drop-in responder for a harness that drives lhs/rhs_vld and ties result_rdy high.
// PARAMETERS
//   W  8  operand/quotient width in bits (W >= 2); iteration count = W
// PORTS
//   clk         in   1  clock, all state on rising edge
//   rst         in   1  reset, synchronous, active-high
//   lhs         in   W  dividend, unsigned
//   lhs_vld     in   1  dividend valid
//   lhs_rdy     out  1  dividend ready
//   rhs         in   W  divisor, unsigned
//   rhs_vld     in   1  divisor valid
//   rhs_rdy     out  1  divisor ready
//   result      out  W  quotient floor(lhs/rhs); all-ones when rhs==0
//   result_vld  out  1  quotient valid
//   result_rdy  in   1  consumer ready
// BEHAVIOUR
//   Transfer on a channel = vld & rdy sampled at a rising clk edge.
//   States: IDLE (collect operands), BUSY (iterate), DONE (offer result).
//   Reset: state=IDLE, lhs_held=rhs_held=0, result=0, result_vld=0, counter=0.
//     lhs_rdy/rhs_rdy are forced 0 while rst=1.
//   IDLE:
//     lhs_rdy = !lhs_held and rhs_rdy = !rhs_held (combinational from state, gated by !rst).
//     Operands latch independently, in either order or in the same cycle.
//     vld held while that operand's held flag=1 is ignored; the first value is kept.
//     On the edge completing both operands: state->BUSY, rem=0, quo=lhs, cnt=W-1.
//   BUSY: both rdy=0. Each cycle:
//     t = {rem[W-2:0], quo[W-1]}; quo = quo<<1;
//     if t >= rhs then rem = t - rhs and quo[0] = 1, else rem = t.
//     rem/t are W bits; t >= rhs compare is unsigned, W+1-bit safe.
//     cnt decrements each cycle. On the edge where cnt==0: result<=quo (final),
//     result_vld<=1, state->DONE.
//   Latency: if the completing operand is accepted at edge E, result_vld rises after
//     edge E+W and is observed W cycles after the acceptance cycle. Latency is fixed
//     and data-independent.
//   rhs==0: no special path. Restoring division yields quotient all-ones
//     (2^W-1), same latency.
//   DONE: result and result_vld stay stable while result_rdy=0 (indefinite backpressure).
//     On the result transfer edge: result_vld->0, held flags->0, state->IDLE.
//     lhs_rdy/rhs_rdy rise the following cycle; no operand is accepted in the
//     transfer cycle.
//     result keeps its last value after consumption; only result_vld qualifies it.
//   Reset mid-operation (any state) aborts: partial operands and result discarded,
//     result_vld=0 in the cycle after the rst edge, IDLE state restored.
//   One division in flight; minimum issue interval = W+2 cycles with result_rdy=1.
//   No X propagation: all registers reset; lhs/rhs are sampled only on transfer.
// TESTING
//   1. W=8, lhs=200/rhs=7 same cycle, result_rdy=1 -> result=28, vld 8 cycles later,
//      1-cycle pulse.
//   2. lhs=255, rhs=0 -> result=255 (0xFF) after 8 cycles; lhs=0, rhs=5 -> result=0.
//   3. lhs=100 at cycle 0, rhs=10 at cycle 5 (lhs_vld held high throughout)
//      -> lhs_rdy low from cycle 1; result=10 valid 8 cycles after cycle 5.
//   4. lhs=5, rhs=9, result_rdy=0 for 10 cycles after vld -> result=0 and vld stable;
//      rdy=1 -> vld drops; lhs_rdy=1 next cycle.
//   5. rst pulsed on BUSY iteration 3 of 81/9 -> no result_vld; then 81/9 reissued
//      -> 9 after 8 cycles.
//   6. back-to-back harness (go held, result_rdy=1): 200/7, 9/3, 128/128
//      -> 28, 3, 1; 10-cycle issue interval.

Source files
------------

// File: rtl/iterative_divider_responder.sv
// Responder for the lhs/rhs/result valid-ready division channels.
// Restoring division, one quotient bit per cycle; quotient is all-ones for a zero divisor.
module iterative_divider_responder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_lhs,
  input  logic         i_lhs_vld,
  output logic         o_lhs_rdy,
  input  logic [W-1:0] i_rhs,
  input  logic         i_rhs_vld,
  output logic         o_rhs_rdy,
  output logic [W-1:0] o_result,
  output logic         o_result_vld,
  input  logic         i_result_rdy
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_lhs_held;
  logic          r_rhs_held;
  logic [W-1:0]  r_lhs;
  logic [W-1:0]  r_rhs;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_result;
  logic          r_result_vld;

  logic          w_lhs_xfer;
  logic          w_rhs_xfer;
  logic          w_lhs_have;
  logic          w_rhs_have;
  logic [W-1:0]  w_lhs_val;
  logic [W-1:0]  w_rhs_val;
  logic [W-1:0]  w_t;
  logic [W-1:0]  w_rem_nxt;
  logic          w_bit;
  logic [W-1:0]  w_quo_nxt;

  assign o_lhs_rdy    = !rst && (r_state == S_IDLE) && !r_lhs_held;
  assign o_rhs_rdy    = !rst && (r_state == S_IDLE) && !r_rhs_held;
  assign o_result     = r_result;
  assign o_result_vld = r_result_vld;

  // A held operand keeps its first value; later vld on that channel is ignored.
  assign w_lhs_xfer = i_lhs_vld && o_lhs_rdy;
  assign w_rhs_xfer = i_rhs_vld && o_rhs_rdy;
  assign w_lhs_have = r_lhs_held || w_lhs_xfer;
  assign w_rhs_have = r_rhs_held || w_rhs_xfer;
  assign w_lhs_val  = r_lhs_held ? r_lhs : i_lhs;
  assign w_rhs_val  = r_rhs_held ? r_rhs : i_rhs;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    w_t       = {r_rem[W-2:0], r_quo[W-1]};
    w_rem_nxt = w_t;
    w_bit     = 1'b0;
    if (w_t >= r_rhs) begin
      w_rem_nxt = w_t - r_rhs;
      w_bit     = 1'b1;
    end else begin
      w_rem_nxt = w_t;
      w_bit     = 1'b0;
    end
    w_quo_nxt = {r_quo[W-2:0], w_bit};
  end

  // Control FSM with operand capture, iteration and result hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lhs_held   <= 1'b0;
      r_rhs_held   <= 1'b0;
      r_lhs        <= {W{1'b0}};
      r_rhs        <= {W{1'b0}};
      r_rem        <= {W{1'b0}};
      r_quo        <= {W{1'b0}};
      r_cnt        <= {CW{1'b0}};
      r_result     <= {W{1'b0}};
      r_result_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_lhs_xfer) begin
            r_lhs      <= i_lhs;
            r_lhs_held <= 1'b1;
          end
          if (w_rhs_xfer) begin
            r_rhs_held <= 1'b1;
          end
          if (w_lhs_have && w_rhs_have) begin
            r_state <= S_BUSY;
            r_rem   <= {W{1'b0}};
            r_quo   <= w_lhs_val;
            r_rhs   <= w_rhs_val;
            r_cnt   <= CW'(W - 1);
          end else if (w_rhs_xfer) begin
            r_rhs   <= i_rhs;
          end
        end
        S_BUSY: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == {CW{1'b0}}) begin
            r_result     <= w_quo_nxt;
            r_result_vld <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          // Ready rises only in the cycle after the result is taken.
          if (i_result_rdy) begin
            r_result_vld <= 1'b0;
            r_lhs_held   <= 1'b0;
            r_rhs_held   <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider_responder.sv
// Scoreboard bench for iterative_divider_responder: a driver pushes expected quotients,
// a negedge monitor pops and checks them along with latency, hold and ready behaviour.
module tb_iterative_divider_responder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] i_lhs = '0;
  logic         i_lhs_vld = 1'b0;
  logic         o_lhs_rdy;
  logic [W-1:0] i_rhs = '0;
  logic         i_rhs_vld = 1'b0;
  logic         o_rhs_rdy;
  logic [W-1:0] o_result;
  logic         o_result_vld;
  logic         i_result_rdy = 1'b1;

  iterative_divider_responder #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_lhs        (i_lhs),
    .i_lhs_vld    (i_lhs_vld),
    .o_lhs_rdy    (o_lhs_rdy),
    .i_rhs        (i_rhs),
    .i_rhs_vld    (i_rhs_vld),
    .o_rhs_rdy    (o_rhs_rdy),
    .o_result     (o_result),
    .o_result_vld (o_result_vld),
    .i_result_rdy (i_result_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   last_acc = 0;
  int   rdy_mode = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [W-1:0] ref_div(input logic [W-1:0] l, input logic [W-1:0] r);
    if (r == 0) return {W{1'b1}};
    return W'(int'(l) / int'(r));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Consumer ready: 0 = always ready, 1 = random backpressure, 2 = stalled.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: i_result_rdy = 1'b1;
        1: i_result_rdy = ($urandom_range(0, 2) != 0);
        default: i_result_rdy = 1'b0;
      endcase
    end
  end

  // Offer one operand pair; dl/dr are cycles before each vld rises; hold keeps vld
  // high with junk data after that operand is taken.
  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r,
                      input int dl, input int dr, input bit hold);
    bit ld = 0;
    bit rd = 0;
    int c = 0;
    while (!(ld && rd) && c < 300) begin
      i_lhs_vld = (!ld && c >= dl) || (ld && hold);
      i_lhs     = ld ? W'($urandom) : l;
      i_rhs_vld = (!rd && c >= dr) || (rd && hold);
      i_rhs     = rd ? W'($urandom) : r;
      @(negedge clk);
      if (ld && hold) check("lhs_rdy_while_held", o_lhs_rdy, 0);
      if (rd && hold) check("rhs_rdy_while_held", o_rhs_rdy, 0);
      if (!ld && i_lhs_vld && o_lhs_rdy) ld = 1;
      if (!rd && i_rhs_vld && o_rhs_rdy) rd = 1;
      if (ld && rd) begin
        last_acc = cyc + 1;
        sb.push_back('{ref_div(l, r), cyc + 1});
      end
      @(posedge clk);
      #1;
      c++;
    end
    i_lhs_vld = 1'b0;
    i_rhs_vld = 1'b0;
    check("send_accepted", (ld && rd), 1);
  endtask

  task automatic drain();
    int c = 0;
    while (sb.size() > 0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    sb.delete();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Output monitor: latency on vld rise, quotient on transfer, stability under stall.
  logic         prev_vld = 1'b0;
  logic         prev_hold = 1'b0;
  logic         chk_rdy = 1'b0;
  logic [W-1:0] prev_res = '0;
  exp_t         e;

  always @(negedge clk) begin
    if (rst) begin
      prev_vld  = 1'b0;
      prev_hold = 1'b0;
      chk_rdy   = 1'b0;
    end else begin
      if (chk_rdy) begin
        check("rdy_after_xfer", {o_lhs_rdy, o_rhs_rdy}, 2'b11);
        chk_rdy = 1'b0;
      end
      if (prev_hold) check("hold_stable", {o_result_vld, o_result}, {1'b1, prev_res});
      if (o_result_vld && !prev_vld) begin
        check("vld_with_pending", (sb.size() > 0), 1);
        if (sb.size() > 0) check("latency", cyc, sb[0].acc + W);
      end
      if (o_result_vld && i_result_rdy && sb.size() > 0) begin
        e = sb.pop_front();
        check("quotient", o_result, e.q);
        chk_rdy = 1'b1;
      end
      prev_hold = o_result_vld && !i_result_rdy;
      prev_res  = o_result;
      prev_vld  = o_result_vld;
    end
  end

  initial begin
    int a0;
    int c;
    logic [W-1:0] l;
    logic [W-1:0] r;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_vld", o_result_vld, 0);
    check("reset_result", o_result, 0);
    check("reset_rdy", {o_lhs_rdy, o_rhs_rdy}, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_rdy", {o_lhs_rdy, o_rhs_rdy}, 2'b11);
    @(posedge clk);
    #1;

    // 200/7 together, then single-cycle pulse and retained result
    send(8'd200, 8'd7, 0, 0, 0);
    drain();
    @(negedge clk);
    check("vld_pulse", o_result_vld, 0);
    check("result_kept", o_result, 28);
    @(posedge clk);
    #1;

    // zero divisor and zero dividend
    send(8'd255, 8'd0, 0, 0, 0);
    drain();
    send(8'd0, 8'd5, 0, 0, 0);
    drain();

    // lhs first with vld held, rhs five cycles later
    send(8'd100, 8'd10, 0, 5, 1);
    drain();

    // indefinite backpressure for 10 cycles
    rdy_mode = 2;
    send(8'd5, 8'd9, 0, 0, 0);
    c = 0;
    while (!o_result_vld && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("stall_vld_seen", o_result_vld, 1);
    repeat (10) @(posedge clk);
    #1;
    rdy_mode = 0;
    drain();

    // reset during the third iteration aborts, then reissue
    send(8'd81, 8'd9, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    do_reset(1);
    repeat (W + 4) @(posedge clk);
    #1;
    send(8'd81, 8'd9, 0, 0, 0);
    drain();

    // back-to-back issue at the minimum interval
    send(8'd200, 8'd7, 0, 0, 0);
    a0 = last_acc;
    send(8'd9, 8'd3, 0, 0, 0);
    check("issue_interval", last_acc - a0, W + 2);
    a0 = last_acc;
    send(8'd128, 8'd128, 0, 0, 0);
    check("issue_interval2", last_acc - a0, W + 2);
    drain();

    // randomized operands, ordering and backpressure
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      l = W'($urandom);
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = W'($urandom_range(1, 3));
        default: r = W'($urandom);
      endcase
      send(l, r, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
